pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline control unit for the 6-stage RISC-V core (PC, IF, ID, EX, MEM, WB). It merges per-stage stall requests into the `stall[5:0]` vector and arbitrates redirect requests (exception, mret, branch/jump) into the `flush`/`new_pc_o` pair consumed by the PC register and the stage registers. A redirect raised during a memory-bus stall is parked in a pending slot. The redirect then fires once the bus access completes. The block also keeps saturating stall/flush statistics and a stall watchdog for debug.

## Interface
- `TRAP_VEC`, 32'h0000_0004, exception entry address
- `TIMEOUT`, 16'd1024, consecutive-stall cycles before `stall_timeout` sets (valid range 1..65535)
- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `stallreq_id`  in  1  ID hazard (load-use) stall request
- `stallreq_ex`  in  1  EX multi-cycle op stall request
- `stallreq_mem`  in  1  MEM bus access not complete
- `excp_req`  in  1  exception raised by instruction in MEM
- `mret_req`  in  1  mret committing in MEM
- `mepc_i`  in  32  return address for mret
- `branch_req`  in  1  taken branch/jump resolved in EX
- `branch_target_i`  in  32  branch/jump target
- `stall`  out  6  per-stage hold, bit0=PC … bit5=WB
- `flush`  out  1  redirect grant, one cycle per redirect
- `new_pc_o`  out  32  redirect target, valid when `flush`=1
- `stall_cnt`  out  32  cycles with `stall[0]`=1, saturating
- `flush_cnt`  out  32  number of granted redirects, saturating
- `stall_timeout`  out  1  sticky watchdog flag

## Operation
- **Stall encoding, highest priority first**
  - `stallreq_mem` → 6'b011111
  - `stallreq_ex` → 6'b001111
  - `stallreq_id` → 6'b000111
  - none → 6'b000000
- **Redirect class priority:** excp (2) > mret (1) > branch (0). Targets are `TRAP_VEC`, `mepc_i`, and `branch_target_i` respectively.
- **State:** `pend_v`, `pend_cls[1:0]`, and `pend_pc[31:0]`. Reset clears all three.
- **Winner:** the winning candidate is the highest class among `pend_v`'s entry and the incoming requests. If classes are equal, the pending entry wins.
- **Grant condition:** `stallreq_mem`=0 and a winner exists.
- **On grant:**
  - `flush`=1 and `new_pc_o`=winner target.
  - `stall` is forced to 6'b000000, because flushed stages' requests are void.
  - `pend_v` clears at the clock edge.
  - All other simultaneous requests are dropped.
- **No grant, with `stallreq_mem`=1:**
  - If an incoming request's class is greater than `pend_cls`, or `pend_v`=0, the request is captured into the pending slot. `mepc_i` and `branch_target_i` are sampled that cycle.
  - Lower or equal classes are ignored.
  - `flush`=0 and `new_pc_o`=0.
- `flush` and `new_pc_o` are combinational from the current inputs and pending state. `pc_reg` samples them at the same edge.
- **`stall_cnt`:** +1 on each edge where `stall[0]`=1. It holds at 32'hFFFF_FFFF.
- **`flush_cnt`:** +1 per grant. It holds at 32'hFFFF_FFFF.
- **Watchdog:**
  - A 16-bit `run` counter increments while `stall[0]`=1. It clears to 0 on any cycle with `stall[0]`=0.
  - When `run` reaches `TIMEOUT`, `stall_timeout` sets and stays set until `rst`.
  - `run` saturates at 16'hFFFF.

## Timing
- **Reset values:** `stall`=0, `flush`=0, `new_pc_o`=0, `stall_cnt`=0, `flush_cnt`=0, `stall_timeout`=0, `pend_v`=0.
- **Reset mid-operation:** a pending redirect is discarded. `rst` overrides all inputs in the same cycle, so outputs are 0 during reset.
- **Latency:**
  - An unblocked redirect has 0 cycles latency. `flush` is high in the request cycle, and PC = target after that edge.
  - A blocked redirect fires in the first cycle with `stallreq_mem`=0.
- **Flush pulse:** `flush` is never high for two consecutive cycles due to the same pending entry. Back-to-back grants are legal only for new requests.
- **Registered vs combinational outputs:** counters and the sticky flag are registered and update one edge after the qualifying cycle. `stall` is combinational.
- **`stall_timeout` timing:** it is visible in the cycle after the edge where `run` becomes equal to `TIMEOUT`.

## Test plan
- **Stall priority:** drive `stallreq_id`=1 → `stall`=6'b000111. Add `stallreq_ex` → 6'b001111. Add `stallreq_mem` → 6'b011111, and `stall_cnt` increments each cycle.
- **Unblocked branch:** `branch_req`=1, `branch_target_i`=32'h0000_0100 → same-cycle `flush`=1, `new_pc_o`=32'h100, `stall`=0. Next cycle `flush_cnt`=1.
- **Simultaneous requests:** `excp_req`, `mret_req`, and `branch_req` all high, `mepc_i`=32'h80 → `new_pc_o`=`TRAP_VEC`, one flush only.
- **Deferred redirect:**
  - `stallreq_mem`=1 for 3 cycles, with `branch_req` (target 32'h200) in cycle 1 and `excp_req` in cycle 2 → `flush`=0 throughout.
  - `stallreq_mem` drops in cycle 4 → `flush`=1, `new_pc_o`=`TRAP_VEC`.
  - Cycle 5 → `flush`=0.
- **Reset mid-pending:** capture an mret (`mepc_i`=32'h40) under a mem stall, assert `rst` for 1 cycle, then drop all requests → `flush` never asserts, and all outputs are 0.
- **Watchdog:** with `TIMEOUT`=8, hold `stallreq_ex` for 7 cycles → `stall_timeout`=0. Continue holding to 8 cycles → flag sets. Release → flag stays 1 until `rst`.

Source files
------------

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, redirect arbitration with pending slot, stats and watchdog
// A redirect blocked by a memory-bus stall is parked and fires once the bus access completes.
module pipe_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0004,
  parameter logic [15:0] TIMEOUT  = 16'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        excp_req,
  input  logic        mret_req,
  input  logic [31:0] mepc_i,
  input  logic        branch_req,
  input  logic [31:0] branch_target_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic        stall_timeout
);

  logic        pend_v_q, pend_v_d;
  logic [1:0]  pend_cls_q, pend_cls_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [15:0] run_q, run_d;
  logic        timeout_q, timeout_d;

  logic        in_v;
  logic [1:0]  in_cls;
  logic [31:0] in_pc;
  logic        use_pend;
  logic        win_v;
  logic [31:0] win_pc;
  logic        grant;
  logic        capture;
  logic [5:0]  stall_enc;

  always_comb begin
    in_v   = 1'b1;
    in_cls = 2'd0;
    in_pc  = 32'h0;
    if (excp_req) begin
      in_cls = 2'd2;
      in_pc  = TRAP_VEC;
    end else if (mret_req) begin
      in_cls = 2'd1;
      in_pc  = mepc_i;
    end else if (branch_req) begin
      in_cls = 2'd0;
      in_pc  = branch_target_i;
    end else begin
      in_v = 1'b0;
    end
  end

  always_comb begin
    stall_enc = 6'b000000;
    if (stallreq_mem)     stall_enc = 6'b011111;
    else if (stallreq_ex) stall_enc = 6'b001111;
    else if (stallreq_id) stall_enc = 6'b000111;
  end

  // Equal class: the older, parked redirect wins.
  assign use_pend = pend_v_q && (!in_v || (pend_cls_q >= in_cls));
  assign win_v    = pend_v_q || in_v;
  assign win_pc   = use_pend ? pend_pc_q : in_pc;
  assign grant    = !rst && !stallreq_mem && win_v;
  assign capture  = !rst && stallreq_mem && in_v && (!pend_v_q || (in_cls > pend_cls_q));

  assign flush    = grant;
  assign new_pc_o = grant ? win_pc : 32'h0;
  assign stall    = (rst || grant) ? 6'b000000 : stall_enc;

  always_comb begin
    pend_v_d    = pend_v_q;
    pend_cls_d  = pend_cls_q;
    pend_pc_d   = pend_pc_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    run_d       = run_q;
    timeout_d   = timeout_q;
    if (grant) begin
      pend_v_d = 1'b0;
    end else if (capture) begin
      pend_v_d   = 1'b1;
      pend_cls_d = in_cls;
      pend_pc_d  = in_pc;
    end
    if (grant && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    if (stall[0]) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
      if (run_q != 16'hFFFF)            run_d       = run_q + 16'd1;
    end else begin
      run_d = 16'd0;
    end
    if (run_d == TIMEOUT) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q    <= 1'b0;
      pend_cls_q  <= 2'd0;
      pend_pc_q   <= 32'h0;
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
      run_q       <= 16'd0;
      timeout_q   <= 1'b0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_cls_q  <= pend_cls_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      run_q       <= run_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id, stallreq_ex, stallreq_mem;
  logic        excp_req, mret_req, branch_req;
  logic [31:0] mepc_i, branch_target_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc_o, stall_cnt, flush_cnt;
  logic        stall_timeout;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.TRAP_VEC(32'h0000_0004), .TIMEOUT(16'd8)) dut (
    .clk(clk), .rst(rst),
    .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excp_req(excp_req), .mret_req(mret_req), .mepc_i(mepc_i),
    .branch_req(branch_req), .branch_target_i(branch_target_i),
    .stall(stall), .flush(flush), .new_pc_o(new_pc_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic idle();
    stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excp_req = 0; mret_req = 0; branch_req = 0;
    mepc_i = 32'h0; branch_target_i = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst = 1;
    branch_req = 1; branch_target_i = 32'h0000_0999; stallreq_id = 1;
    settle();
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_stall", {26'b0, stall}, 32'h0);
    check("rst_newpc", new_pc_o, 32'h0);
    tick(); tick();
    rst = 0; idle();
    settle();
    check("reset_stall_cnt", stall_cnt, 32'h0);
    check("reset_flush_cnt", flush_cnt, 32'h0);
    check("reset_timeout", {31'b0, stall_timeout}, 32'h0);
    check("reset_flush", {31'b0, flush}, 32'h0);

    // stall priority
    stallreq_id = 1; settle();
    check("stall_id", {26'b0, stall}, 32'h07);
    tick();
    stallreq_ex = 1; settle();
    check("stall_ex", {26'b0, stall}, 32'h0F);
    tick();
    stallreq_mem = 1; settle();
    check("stall_mem", {26'b0, stall}, 32'h1F);
    tick();
    check("stall_cnt_3", stall_cnt, 32'd3);
    idle(); settle();
    check("stall_none", {26'b0, stall}, 32'h0);
    tick();

    // unblocked branch, stall request voided by the flush
    branch_req = 1; branch_target_i = 32'h0000_0100; stallreq_id = 1; settle();
    check("br_flush", {31'b0, flush}, 32'h1);
    check("br_newpc", new_pc_o, 32'h100);
    check("br_stall", {26'b0, stall}, 32'h0);
    tick();
    check("br_flush_cnt", flush_cnt, 32'd1);
    check("br_stall_cnt", stall_cnt, 32'd3);

    // simultaneous requests
    idle();
    excp_req = 1; mret_req = 1; branch_req = 1; mepc_i = 32'h80; branch_target_i = 32'h300; settle();
    check("sim_flush", {31'b0, flush}, 32'h1);
    check("sim_newpc", new_pc_o, 32'h4);
    tick();
    idle(); settle();
    check("sim_flush_after", {31'b0, flush}, 32'h0);
    check("sim_flush_cnt", flush_cnt, 32'd2);

    // deferred redirect, excp upgrades a parked branch
    stallreq_mem = 1; branch_req = 1; branch_target_i = 32'h200; settle();
    check("def_c1_flush", {31'b0, flush}, 32'h0);
    check("def_c1_newpc", new_pc_o, 32'h0);
    check("def_c1_stall", {26'b0, stall}, 32'h1F);
    tick();
    idle(); stallreq_mem = 1; excp_req = 1; settle();
    check("def_c2_flush", {31'b0, flush}, 32'h0);
    tick();
    idle(); stallreq_mem = 1; settle();
    check("def_c3_flush", {31'b0, flush}, 32'h0);
    tick();
    idle(); settle();
    check("def_c4_flush", {31'b0, flush}, 32'h1);
    check("def_c4_newpc", new_pc_o, 32'h4);
    check("def_c4_stall", {26'b0, stall}, 32'h0);
    tick();
    check("def_c5_flush", {31'b0, flush}, 32'h0);
    check("def_flush_cnt", flush_cnt, 32'd3);
    check("def_stall_cnt", stall_cnt, 32'd6);

    // equal class: parked entry kept and wins over new equal-class request
    stallreq_mem = 1; branch_req = 1; branch_target_i = 32'h500; tick();
    branch_target_i = 32'h600; settle();
    check("eq_hold_flush", {31'b0, flush}, 32'h0);
    tick();
    stallreq_mem = 0; branch_target_i = 32'h700; settle();
    check("eq_flush", {31'b0, flush}, 32'h1);
    check("eq_newpc", new_pc_o, 32'h500);
    tick();
    idle(); settle();
    check("eq_flush_after", {31'b0, flush}, 32'h0);
    check("eq_flush_cnt", flush_cnt, 32'd4);
    check("eq_stall_cnt", stall_cnt, 32'd8);

    // reset discards a parked mret
    stallreq_mem = 1; mret_req = 1; mepc_i = 32'h40; settle();
    check("rp_capture_flush", {31'b0, flush}, 32'h0);
    tick();
    idle(); rst = 1; settle();
    check("rp_rst_flush", {31'b0, flush}, 32'h0);
    tick();
    rst = 0; settle();
    check("rp_flush", {31'b0, flush}, 32'h0);
    check("rp_newpc", new_pc_o, 32'h0);
    check("rp_stall_cnt", stall_cnt, 32'h0);
    check("rp_flush_cnt", flush_cnt, 32'h0);
    tick();
    check("rp_flush_later", {31'b0, flush}, 32'h0);

    // watchdog with TIMEOUT = 8
    stallreq_ex = 1;
    for (int i = 0; i < 7; i++) tick();
    check("wd_7", {31'b0, stall_timeout}, 32'h0);
    tick();
    check("wd_8", {31'b0, stall_timeout}, 32'h1);
    idle(); tick(); tick();
    check("wd_sticky", {31'b0, stall_timeout}, 32'h1);
    check("wd_stall_cnt", stall_cnt, 32'd8);
    rst = 1; tick();
    rst = 0; settle();
    check("wd_rst", {31'b0, stall_timeout}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
